ncc_search_ctrl: RTL
====================

// Module: ncc_search_ctrl
// PURPOSE
//  Sequencer for the ncc correlation engine. On start, streams one descriptor (DESC_WORDS x 32b)
//  from descriptor RAM into ncc, then steps through NUM_WINDOWS candidate windows: requests each
//  from the window loader, fires ncc, collects the score, tracks the best. Sits between tracker top FSM, desc RAM, window loader and ncc.
// PARAMETERS
//  DESC_WORDS   64   32b descriptor words per patch (16x16 bytes)
//  NUM_WINDOWS  289  windows per search (17x17 offsets); max 512
//  IDX_W        9    width of window index
//  SCORE_W      32   width of ncc score (unsigned)
//  TIMEOUT      255  max cycles waiting on any handshake before ERR
// PORTS
//  clk                 in   1        clock
//  rst                 in   1        synchronous active-high reset
//  start               in   1        begin search (accepted in IDLE/ERR only)
//  abort               in   1        cancel search, return to IDLE
//  busy                out  1        high in any state except IDLE/ERR
//  done                out  1        1-cycle pulse, search complete
//  error               out  1        sticky timeout flag
//  desc_rd_addr        out  6        descriptor RAM word address
//  desc_rd_data        in   32       RAM data, 1-cycle read latency
//  desc_data_ready     out  1        to ncc: desc_in valid this cycle
//  desc_in             out  32       to ncc: descriptor word
//  done_with_desc_data in   1        from ncc: descriptor absorbed
//  win_req             out  1        to loader: present window win_idx
//  win_idx             out  IDX_W    current window index
//  win_valid           in   1        from loader: window driven onto ncc windowIn
//  window_data_ready   out  1        to ncc: start correlation
//  done_with_window_data in 1        from ncc: score valid
//  ncc_score           in   SCORE_W  ncc greatestNCC for current window
//  best_score          out  SCORE_W  best score of last search
//  best_idx            out  IDX_W    window index of best_score
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0. Cleared only by rst; start clears best_*/error.
//  IDLE: start -> DESC_LOAD; clear best_score, best_idx, win_idx, desc_rd_addr, error.
//  DESC_LOAD: desc_rd_addr counts 0..DESC_WORDS-1, one per cycle. desc_data_ready high for
//   exactly DESC_WORDS cycles, delayed 1 cycle from addr (desc_in = desc_rd_data); then DESC_WAIT.
//  DESC_WAIT: done_with_desc_data -> WIN_FETCH.
//  WIN_FETCH: win_req high, win_idx stable; win_valid -> WIN_FIRE (win_req drops same edge).
//  WIN_FIRE: window_data_ready high exactly 1 cycle -> WIN_WAIT.
//  WIN_WAIT: on done_with_window_data sample ncc_score; if ncc_score > best_score (unsigned,
//   strict; ties keep earlier index) load best_score/best_idx. If win_idx==NUM_WINDOWS-1 ->
//   DONE, else win_idx++ -> WIN_FETCH.
//  DONE: done=1 one cycle -> IDLE. best_* held until next start.
//  Timeout: cycle counter reset on every state entry; in DESC_WAIT/WIN_FETCH/WIN_WAIT, counter
//   reaching TIMEOUT -> ERR. Handshake arriving on the expiry cycle wins over timeout.
//  ERR: error=1, busy=0, strobes low; start restarts search (clears error).
//  abort (any busy state): next cycle IDLE, all strobes low, no done, best_* keep partial values.
//   abort same cycle as start in IDLE: abort wins, stay IDLE.
//  start while busy: ignored. Inputs handshakes outside their waiting state: ignored.
//  Minimum latency start->done: 1 + DESC_WORDS+1 + NUM_WINDOWS*(3) + ncc/loader waits.
// TESTING
//  1 Nominal: NUM_WINDOWS=4, scores 10,40,25,40, all handshakes 1 cycle -> best_score=40,
//    best_idx=1, done single pulse, desc_data_ready high exactly 64 cycles, addr 0..63.
//  2 Descriptor order: RAM word n = n*3 -> desc_in on k-th ready cycle == 3k for k=0..63.
//  3 Timeout: loader never asserts win_valid for idx 2 -> error=1 after 255 cycles in
//    WIN_FETCH, busy=0, done never; next start clears error and completes normally.
//  4 Abort mid-WIN_WAIT at idx 3 -> IDLE next cycle, window_data_ready/win_req low, no done;
//    subsequent start gives fresh best_score from 0.
//  5 Edge: all scores 0 -> best_score=0, best_idx=0; score 0xFFFFFFFF at last idx ->
//    best_idx=NUM_WINDOWS-1 (unsigned compare).
//  6 rst asserted during DESC_LOAD -> all outputs 0 next cycle; start during busy ignored.

Source files
------------

// File: rtl/ncc_search_ctrl.sv
// ncc_search_ctrl: loads one descriptor into ncc, then scores each candidate window in turn and keeps the best.
// Every handshake wait is bounded by TIMEOUT cycles; expiry parks the block in ERR until the next start.
module ncc_search_ctrl #(
    parameter int DESC_WORDS  = 64,
    parameter int NUM_WINDOWS = 289,
    parameter int IDX_W       = 9,
    parameter int SCORE_W     = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [5:0]         desc_rd_addr,
    input  logic [31:0]        desc_rd_data,
    output logic               desc_data_ready,
    output logic [31:0]        desc_in,
    input  logic               done_with_desc_data,
    output logic               win_req,
    output logic [IDX_W-1:0]   win_idx,
    input  logic               win_valid,
    output logic               window_data_ready,
    input  logic               done_with_window_data,
    input  logic [SCORE_W-1:0] ncc_score,
    output logic [SCORE_W-1:0] best_score,
    output logic [IDX_W-1:0]   best_idx
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [5:0] LAST_ADDR = 6'(DESC_WORDS - 1);
    localparam logic [IDX_W-1:0] LAST_WIN = IDX_W'(NUM_WINDOWS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DESC_LOAD = 3'd1,
        DESC_WAIT = 3'd2,
        WIN_FETCH = 3'd3,
        WIN_FIRE  = 3'd4,
        WIN_WAIT  = 3'd5,
        DONE      = 3'd6,
        ERR       = 3'd7
    } state_t;

    state_t state, state_n;
    logic [CNT_W-1:0] cnt;
    logic expired, launch, take;

    // A handshake landing on the expiry cycle is taken ahead of the timeout.
    always_comb begin
        busy = state != IDLE && state != ERR;
        expired = cnt == CNT_W'(TIMEOUT - 1);
        state_n = state;
        case (state)
            IDLE, ERR: state_n = start && !abort ? DESC_LOAD : state;
            DESC_LOAD: state_n = desc_rd_addr == LAST_ADDR ? DESC_WAIT : DESC_LOAD;
            DESC_WAIT: state_n = done_with_desc_data ? WIN_FETCH : expired ? ERR : DESC_WAIT;
            WIN_FETCH: state_n = win_valid ? WIN_FIRE : expired ? ERR : WIN_FETCH;
            WIN_FIRE:  state_n = WIN_WAIT;
            WIN_WAIT:  state_n = done_with_window_data ? (win_idx == LAST_WIN ? DONE : WIN_FETCH) :
                                 expired ? ERR : WIN_WAIT;
            DONE:      state_n = IDLE;
            default:   state_n = IDLE;
        endcase
        if (busy && abort) state_n = IDLE;
        launch = !busy && state_n == DESC_LOAD;
        take = state == WIN_WAIT && done_with_window_data && !abort;
    end

    assign done = state == DONE;
    assign error = state == ERR;
    assign win_req = state == WIN_FETCH;
    assign window_data_ready = state == WIN_FIRE;
    assign desc_in = desc_data_ready ? desc_rd_data : '0;

    // desc_data_ready trails the address by the RAM's one-cycle read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            desc_rd_addr <= '0;
            desc_data_ready <= 1'b0;
            win_idx <= '0;
            best_score <= '0;
            best_idx <= '0;
        end else begin
            state <= state_n;
            cnt <= state_n == state ? cnt + 1'b1 : '0;
            desc_data_ready <= state == DESC_LOAD && !abort;
            if (launch) begin
                desc_rd_addr <= '0;
                win_idx <= '0;
                best_score <= '0;
                best_idx <= '0;
            end
            if (state == DESC_LOAD && !abort && desc_rd_addr != LAST_ADDR) desc_rd_addr <= desc_rd_addr + 1'b1;
            if (take && ncc_score > best_score) begin
                best_score <= ncc_score;
                best_idx <= win_idx;
            end
            if (take && win_idx != LAST_WIN) win_idx <= win_idx + 1'b1;
        end
    end
endmodule
